punc_control: RTL and testbench

Control FSM for the PUnC LC3 processor. It sequences the PUnC datapath through fetch, decode and execute for each instruction, driving every mux select, load strobe and write enable the datapath exposes. Its inputs are the instruction register and the N/Z/P flags from the datapath. It sits beside the datapath inside the PUnC top level.

---
 rtl/punc_defines.sv | 98 +++++++++
 rtl/punc_branch_eval.sv | 14 +
 rtl/punc_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_punc_control.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/punc_defines.sv
// Shared PUnC definitions: opcodes, control FSM state encoding and the datapath
// mux-select encodings used by both the control unit and the datapath.
package punc_defines;

    localparam int unsigned WORD_W     = 16;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned REG_ADDR_W = 3;
    localparam int unsigned NZP_W      = 3;
    localparam int unsigned MEM_SEL_W  = 2;
    localparam int unsigned RF_SEL_W   = 2;
    localparam int unsigned ALU_SEL_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXECUTE  = 3'd2,
        S_EXECUTE2 = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [OP_W-1:0] OP_BR   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0001;
    localparam logic [OP_W-1:0] OP_LD   = 4'b0010;
    localparam logic [OP_W-1:0] OP_ST   = 4'b0011;
    localparam logic [OP_W-1:0] OP_JSR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OP_W-1:0] OP_LDR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_STR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_RTI  = 4'b1000;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1001;
    localparam logic [OP_W-1:0] OP_LDI  = 4'b1010;
    localparam logic [OP_W-1:0] OP_STI  = 4'b1011;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1100;
    localparam logic [OP_W-1:0] OP_RES  = 4'b1101;
    localparam logic [OP_W-1:0] OP_LEA  = 4'b1110;
    localparam logic [OP_W-1:0] OP_TRAP = 4'b1111;

    // PC source: adder (PC + offset) or a base register read on rd0
    localparam logic PC_DATA_ADDER  = 1'b0;
    localparam logic PC_DATA_BASE_R = 1'b1;
    localparam logic PC_ADD_OFF11   = 1'b0;
    localparam logic PC_ADD_OFF9    = 1'b1;

    localparam logic [MEM_SEL_W-1:0] ADDR_MEM_PC    = 2'b00;
    localparam logic [MEM_SEL_W-1:0] ADDR_MEM_ALU   = 2'b01;
    localparam logic [MEM_SEL_W-1:0] ADDR_MEM_STORE = 2'b10;

    localparam logic [RF_SEL_W-1:0] W_RF_PC  = 2'b00;
    localparam logic [RF_SEL_W-1:0] W_RF_MEM = 2'b01;
    localparam logic [RF_SEL_W-1:0] W_RF_ALU = 2'b10;

    localparam logic A_SEL_PC   = 1'b0;
    localparam logic A_SEL_RD0  = 1'b1;
    localparam logic B_SEL_RD1  = 1'b0;
    localparam logic B_SEL_SEXT = 1'b1;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 2'b00;
    localparam logic [ALU_SEL_W-1:0] ALU_AND    = 2'b01;
    localparam logic [ALU_SEL_W-1:0] ALU_NOT    = 2'b10;
    localparam logic [ALU_SEL_W-1:0] ALU_PASS_A = 2'b11;

    localparam logic NZP_SEL_ALU = 1'b0;
    localparam logic NZP_SEL_MEM = 1'b1;

    localparam logic [REG_ADDR_W-1:0] LINK_REG = 3'd7;

    // Complete control word driven onto the datapath each cycle
    typedef struct packed {
        logic                  pc_data_sel;
        logic                  pc_add_sel;
        logic                  pc_ld;
        logic                  pc_clr;
        logic                  pc_inc;
        logic                  ir_ld;
        logic [MEM_SEL_W-1:0]  addr_mem_sel;
        logic                  w_en_mem;
        logic [RF_SEL_W-1:0]   w_rf_sel;
        logic [REG_ADDR_W-1:0] r_addr_0;
        logic [REG_ADDR_W-1:0] r_addr_1;
        logic [REG_ADDR_W-1:0] w_addr;
        logic                  w_en_rf;
        logic                  a_sel;
        logic                  b_sel;
        logic [ALU_SEL_W-1:0]  alu_sel;
        logic                  nzp_sel;
        logic                  n_ld;
        logic                  z_ld;
        logic                  p_ld;
        logic                  store_ld;
    } ctrl_t;

    // LDI/STI need a second execute cycle for the indirect access
    function automatic logic is_indirect(input logic [OP_W-1:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/punc_branch_eval.sv
// Branch condition check: BR is taken when any requested nzp bit matches a set flag.
module punc_branch_eval
    import punc_defines::*;
(
    input  logic [NZP_W-1:0] nzp,
    input  logic             n,
    input  logic             z,
    input  logic             p,
    output logic             taken_c
);

    assign taken_c = (nzp[2] & n) | (nzp[1] & z) | (nzp[0] & p);

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: fetch/decode/execute sequencing and datapath control word.
// Build option PUNC_HALT_EN: TRAP enters a sticky HALT state; otherwise TRAP is a NOP.
module punc_control
    import punc_defines::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_W-1:0]     ir,
    input  logic                  n,
    input  logic                  z,
    input  logic                  p,
    output logic                  PC_data_sel,
    output logic                  PC_add_sel,
    output logic                  PC_ld,
    output logic                  PC_clr,
    output logic                  PC_inc,
    output logic                  IR_ld,
    output logic [MEM_SEL_W-1:0]  addr_MEM_sel,
    output logic                  w_en_MEM,
    output logic [RF_SEL_W-1:0]   w_RF_sel,
    output logic [REG_ADDR_W-1:0] r_addr_0_RF,
    output logic [REG_ADDR_W-1:0] r_addr_1_RF,
    output logic [REG_ADDR_W-1:0] w_addr_RF,
    output logic                  w_en_RF,
    output logic                  A_sel,
    output logic                  B_sel,
    output logic [ALU_SEL_W-1:0]  ALU_sel,
    output logic                  NZP_sel,
    output logic                  N_ld,
    output logic                  Z_ld,
    output logic                  P_ld,
    output logic                  store_ld,
    output logic                  halted,
    output logic [STATE_W-1:0]    state
);

    state_t                state_q;
    ctrl_t                 ctrl;
    logic [OP_W-1:0]       opcode;
    logic [REG_ADDR_W-1:0] dr;
    logic [REG_ADDR_W-1:0] sr1;
    logic [REG_ADDR_W-1:0] sr2;
    logic                  imm_mode;
    logic                  br_taken;
    logic                  unused_ir_bits;

    assign opcode         = ir[15:12];
    assign dr             = ir[11:9];
    assign sr1            = ir[8:6];
    assign sr2            = ir[2:0];
    assign imm_mode       = ir[5];
    assign unused_ir_bits = ^ir[4:3];

    punc_branch_eval u_branch_eval (
        .nzp     (ir[11:9]),
        .n       (n),
        .z       (z),
        .p       (p),
        .taken_c (br_taken)
    );

    // State register with next-state selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:    state_q <= S_DECODE;
                S_DECODE:   state_q <= S_EXECUTE;
                S_EXECUTE: begin
                    if (is_indirect(opcode)) begin
                        state_q <= S_EXECUTE2;
`ifdef PUNC_HALT_EN
                    end else if (opcode == OP_TRAP) begin
                        state_q <= S_HALT;
`endif
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_EXECUTE2: state_q <= S_FETCH;
                S_HALT:     state_q <= S_HALT;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // Control word from state and instruction; reset forces everything idle except PC clear
    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl.pc_clr = 1'b1;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ctrl.addr_mem_sel = ADDR_MEM_PC;
                    ctrl.ir_ld        = 1'b1;
                    ctrl.pc_inc       = 1'b1;
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_ADD, OP_AND, OP_NOT: begin
                            ctrl.r_addr_0 = sr1;
                            ctrl.a_sel    = A_SEL_RD0;
                            if (imm_mode) begin
                                ctrl.b_sel = B_SEL_SEXT;
                            end else begin
                                ctrl.b_sel    = B_SEL_RD1;
                                ctrl.r_addr_1 = sr2;
                            end
                            if (opcode == OP_ADD)      ctrl.alu_sel = ALU_ADD;
                            else if (opcode == OP_AND) ctrl.alu_sel = ALU_AND;
                            else                       ctrl.alu_sel = ALU_NOT;
                            ctrl.w_rf_sel = W_RF_ALU;
                            ctrl.w_addr   = dr;
                            ctrl.w_en_rf  = 1'b1;
                            ctrl.nzp_sel  = NZP_SEL_ALU;
                            ctrl.n_ld     = 1'b1;
                            ctrl.z_ld     = 1'b1;
                            ctrl.p_ld     = 1'b1;
                        end
                        OP_BR: begin
                            // Not-taken leaves the already-incremented PC untouched
                            if (br_taken) begin
                                ctrl.pc_data_sel = PC_DATA_ADDER;
                                ctrl.pc_add_sel  = PC_ADD_OFF9;
                                ctrl.pc_ld       = 1'b1;
                            end
                        end
                        OP_JMP: begin
                            ctrl.pc_data_sel = PC_DATA_BASE_R;
                            ctrl.r_addr_0    = sr1;
                            ctrl.pc_ld       = 1'b1;
                        end
                        OP_JSR: begin
                            ctrl.w_addr   = LINK_REG;
                            ctrl.w_rf_sel = W_RF_PC;
                            ctrl.w_en_rf  = 1'b1;
                            ctrl.pc_ld    = 1'b1;
                            if (ir[11]) begin
                                ctrl.pc_data_sel = PC_DATA_ADDER;
                                ctrl.pc_add_sel  = PC_ADD_OFF11;
                            end else begin
                                ctrl.pc_data_sel = PC_DATA_BASE_R;
                                ctrl.r_addr_0    = sr1;
                            end
                        end
                        OP_LD, OP_LDR: begin
                            if (opcode == OP_LDR) begin
                                ctrl.a_sel    = A_SEL_RD0;
                                ctrl.r_addr_0 = sr1;
                            end else begin
                                ctrl.a_sel = A_SEL_PC;
                            end
                            ctrl.b_sel        = B_SEL_SEXT;
                            ctrl.alu_sel      = ALU_ADD;
                            ctrl.addr_mem_sel = ADDR_MEM_ALU;
                            ctrl.w_rf_sel     = W_RF_MEM;
                            ctrl.w_addr       = dr;
                            ctrl.w_en_rf      = 1'b1;
                            ctrl.nzp_sel      = NZP_SEL_MEM;
                            ctrl.n_ld         = 1'b1;
                            ctrl.z_ld         = 1'b1;
                            ctrl.p_ld         = 1'b1;
                        end
                        OP_LEA: begin
                            ctrl.a_sel    = A_SEL_PC;
                            ctrl.b_sel    = B_SEL_SEXT;
                            ctrl.alu_sel  = ALU_ADD;
                            ctrl.w_rf_sel = W_RF_ALU;
                            ctrl.w_addr   = dr;
                            ctrl.w_en_rf  = 1'b1;
                        end
                        OP_ST, OP_STR: begin
                            if (opcode == OP_STR) begin
                                ctrl.a_sel    = A_SEL_RD0;
                                ctrl.r_addr_0 = sr1;
                            end else begin
                                ctrl.a_sel = A_SEL_PC;
                            end
                            ctrl.b_sel        = B_SEL_SEXT;
                            ctrl.alu_sel      = ALU_ADD;
                            ctrl.addr_mem_sel = ADDR_MEM_ALU;
                            ctrl.r_addr_1     = dr;
                            ctrl.w_en_mem     = 1'b1;
                        end
                        OP_LDI, OP_STI: begin
                            // Fetch the pointer word into the store register
                            ctrl.a_sel        = A_SEL_PC;
                            ctrl.b_sel        = B_SEL_SEXT;
                            ctrl.alu_sel      = ALU_ADD;
                            ctrl.addr_mem_sel = ADDR_MEM_ALU;
                            ctrl.store_ld     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_EXECUTE2: begin
                    ctrl.addr_mem_sel = ADDR_MEM_STORE;
                    if (opcode == OP_LDI) begin
                        ctrl.w_rf_sel = W_RF_MEM;
                        ctrl.w_addr   = dr;
                        ctrl.w_en_rf  = 1'b1;
                        ctrl.nzp_sel  = NZP_SEL_MEM;
                        ctrl.n_ld     = 1'b1;
                        ctrl.z_ld     = 1'b1;
                        ctrl.p_ld     = 1'b1;
                    end else begin
                        ctrl.r_addr_1 = dr;
                        ctrl.w_en_mem = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign PC_data_sel  = ctrl.pc_data_sel;
    assign PC_add_sel   = ctrl.pc_add_sel;
    assign PC_ld        = ctrl.pc_ld;
    assign PC_clr       = ctrl.pc_clr;
    assign PC_inc       = ctrl.pc_inc;
    assign IR_ld        = ctrl.ir_ld;
    assign addr_MEM_sel = ctrl.addr_mem_sel;
    assign w_en_MEM     = ctrl.w_en_mem;
    assign w_RF_sel     = ctrl.w_rf_sel;
    assign r_addr_0_RF  = ctrl.r_addr_0;
    assign r_addr_1_RF  = ctrl.r_addr_1;
    assign w_addr_RF    = ctrl.w_addr;
    assign w_en_RF      = ctrl.w_en_rf;
    assign A_sel        = ctrl.a_sel;
    assign B_sel        = ctrl.b_sel;
    assign ALU_sel      = ctrl.alu_sel;
    assign NZP_sel      = ctrl.nzp_sel;
    assign N_ld         = ctrl.n_ld;
    assign Z_ld         = ctrl.z_ld;
    assign P_ld         = ctrl.p_ld;
    assign store_ld     = ctrl.store_ld;
    assign state        = state_q;

`ifdef PUNC_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: a small behavioural PUnC datapath runs directed programs.
module tb_punc_control;
    import punc_defines::*;

    logic        clk;
    logic        rst;
    logic [15:0] ir_r;
    logic        nf, zf, pf;
    logic        PC_data_sel, PC_add_sel, PC_ld, PC_clr, PC_inc, IR_ld;
    logic [1:0]  addr_MEM_sel;
    logic        w_en_MEM;
    logic [1:0]  w_RF_sel;
    logic [2:0]  r_addr_0_RF, r_addr_1_RF, w_addr_RF;
    logic        w_en_RF, A_sel, B_sel;
    logic [1:0]  ALU_sel;
    logic        NZP_sel, N_ld, Z_ld, P_ld, store_ld, halted;
    logic [2:0]  state;

    logic [15:0] mem [0:255];
    logic [15:0] rf  [0:7];
    logic [15:0] pc;
    logic [15:0] store_r;
    int          checks;
    int          errors;

    punc_control dut (
        .clk          (clk),
        .rst          (rst),
        .ir           (ir_r),
        .n            (nf),
        .z            (zf),
        .p            (pf),
        .PC_data_sel  (PC_data_sel),
        .PC_add_sel   (PC_add_sel),
        .PC_ld        (PC_ld),
        .PC_clr       (PC_clr),
        .PC_inc       (PC_inc),
        .IR_ld        (IR_ld),
        .addr_MEM_sel (addr_MEM_sel),
        .w_en_MEM     (w_en_MEM),
        .w_RF_sel     (w_RF_sel),
        .r_addr_0_RF  (r_addr_0_RF),
        .r_addr_1_RF  (r_addr_1_RF),
        .w_addr_RF    (w_addr_RF),
        .w_en_RF      (w_en_RF),
        .A_sel        (A_sel),
        .B_sel        (B_sel),
        .ALU_sel      (ALU_sel),
        .NZP_sel      (NZP_sel),
        .N_ld         (N_ld),
        .Z_ld         (Z_ld),
        .P_ld         (P_ld),
        .store_ld     (store_ld),
        .halted       (halted),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    // One clock of the behavioural datapath driven by the current control word
    task automatic tick();
        logic [15:0] sx, sx9, sx11, op_a, op_b, alu, addr, mrd, pc_next, wdata, cc, mdata;
        logic [3:0]  op;
        logic        we_mem, we_rf, s_ir, s_st, l_n, l_z, l_p, s_clr, s_ld, s_inc;
        logic [2:0]  wa;
        op   = ir_r[15:12];
        sx9  = {{7{ir_r[8]}}, ir_r[8:0]};
        sx11 = {{5{ir_r[10]}}, ir_r[10:0]};
        if (op == OP_ADD || op == OP_AND)      sx = {{11{ir_r[4]}}, ir_r[4:0]};
        else if (op == OP_LDR || op == OP_STR) sx = {{10{ir_r[5]}}, ir_r[5:0]};
        else                                   sx = sx9;
        op_a = (A_sel == A_SEL_RD0) ? rf[r_addr_0_RF] : pc;
        op_b = (B_sel == B_SEL_SEXT) ? sx : rf[r_addr_1_RF];
        case (ALU_sel)
            ALU_ADD: alu = op_a + op_b;
            ALU_AND: alu = op_a & op_b;
            ALU_NOT: alu = ~op_a;
            default: alu = op_a;
        endcase
        case (addr_MEM_sel)
            ADDR_MEM_PC:  addr = pc;
            ADDR_MEM_ALU: addr = alu;
            default:      addr = store_r;
        endcase
        mrd     = mem[addr[7:0]];
        pc_next = (PC_data_sel == PC_DATA_BASE_R) ? rf[r_addr_0_RF]
                : pc + ((PC_add_sel == PC_ADD_OFF9) ? sx9 : sx11);
        case (w_RF_sel)
            W_RF_PC:  wdata = pc;
            W_RF_MEM: wdata = mrd;
            default:  wdata = alu;
        endcase
        cc     = (NZP_sel == NZP_SEL_MEM) ? mrd : alu;
        mdata  = rf[r_addr_1_RF];
        we_mem = w_en_MEM; we_rf = w_en_RF; wa = w_addr_RF;
        s_ir   = IR_ld; s_st = store_ld;
        l_n    = N_ld; l_z = Z_ld; l_p = P_ld;
        s_clr  = PC_clr; s_ld = PC_ld; s_inc = PC_inc;
        @(posedge clk);
        #1;
        if (we_mem) mem[addr[7:0]] = mdata;
        if (we_rf)  rf[wa] = wdata;
        if (s_ir)   ir_r = mrd;
        if (s_st)   store_r = mrd;
        if (l_n)    nf = cc[15];
        if (l_z)    zf = (cc == 16'h0);
        if (l_p)    pf = !cc[15] && (cc != 16'h0);
        if (s_clr)      pc = 16'h0;
        else if (s_ld)  pc = pc_next;
        else if (s_inc) pc = pc + 16'h1;
    endtask

    // Runs one instruction from FETCH and checks its cycle count
    task automatic run_instr(input string tag, input int exp_cycles);
        int cyc;
        cyc = 0;
        check({tag, "_start"}, 16'(state), 16'd0);
        tick();
        cyc++;
        while (state != 3'd0 && state != 3'd4 && cyc < 12) begin
            tick();
            cyc++;
        end
        check({tag, "_cycles"}, 16'(cyc), 16'(exp_cycles));
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; ir_r = 16'h0; nf = 1'b0; zf = 1'b0; pf = 1'b0;
        pc = 16'h0; store_r = 16'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0;
        for (int i = 0; i < 8; i++)   rf[i]  = 16'h0;
        rf[2] = 16'd5; rf[3] = 16'd2; rf[7] = 16'h0040;
        mem[16'h00] = 16'h12BD;   // ADD R1,R2,#-3
        mem[16'h01] = 16'h0405;   // BRz +5
        mem[16'h02] = 16'h56E0;   // AND R3,R3,#0
        mem[16'h03] = 16'h05FE;   // BRz -2
        mem[16'h05] = 16'hA001;   // LDI R0,+1
        mem[16'h06] = 16'h983F;   // NOT R4,R0
        mem[16'h07] = 16'h0030;
        mem[16'h30] = 16'h8000;
        mem[16'h10] = 16'h41C0;   // JSRR R7
        mem[16'h40] = 16'hB801;   // STI R4,+1
        mem[16'h41] = 16'hEBFF;   // LEA R5,-1
        mem[16'h42] = 16'h0050;
        mem[16'h43] = 16'hF025;   // TRAP
        mem[16'h44] = 16'h3802;   // ST R4,+2

        #1;
        check("rst_state", 16'(state), 16'd0);
        check("rst_pc_clr", 16'(PC_clr), 16'd1);
        check("rst_ir_ld", 16'(IR_ld), 16'd0);
        check("rst_pc_inc", 16'(PC_inc), 16'd0);
        check("rst_halted", 16'(halted), 16'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("pc_cleared", pc, 16'h0);
        check("fetch_ir_ld", 16'(IR_ld), 16'd1);
        check("fetch_pc_inc", 16'(PC_inc), 16'd1);
        check("fetch_pc_clr", 16'(PC_clr), 16'd0);

        // ADD R1,R2,#-3 with R2=5, cycle by cycle
        tick();
        check("dec_state", 16'(state), 16'd1);
        check("dec_ir", ir_r, 16'h12BD);
        check("dec_ir_ld", 16'(IR_ld), 16'd0);
        check("dec_w_en_rf", 16'(w_en_RF), 16'd0);
        tick();
        check("exe_state", 16'(state), 16'd2);
        check("exe_w_en_rf", 16'(w_en_RF), 16'd1);
        check("exe_w_addr", 16'(w_addr_RF), 16'd1);
        check("exe_r_addr_0", 16'(r_addr_0_RF), 16'd2);
        check("exe_b_sel", 16'(B_sel), 16'd1);
        check("exe_alu_sel", 16'(ALU_sel), 16'd0);
        check("exe_p_ld", 16'(P_ld), 16'd1);
        tick();
        check("add_state", 16'(state), 16'd0);
        check("add_r1", rf[1], 16'd2);
        check("add_flags", 16'({nf, zf, pf}), 16'b001);
        check("add_pc", pc, 16'h1);

        run_instr("brz_nt", 3);
        check("brz_nt_pc", pc, 16'h2);
        run_instr("and", 3);
        check("and_r3", rf[3], 16'h0);
        check("and_flags", 16'({nf, zf, pf}), 16'b010);
        run_instr("brz_t", 3);
        check("brz_t_pc", pc, 16'h2);

        pc = 16'h5;
        run_instr("ldi", 4);
        check("ldi_r0", rf[0], 16'h8000);
        check("ldi_flags", 16'({nf, zf, pf}), 16'b100);
        check("ldi_pc", pc, 16'h6);
        run_instr("not", 3);
        check("not_r4", rf[4], 16'h7FFF);
        check("not_flags", 16'({nf, zf, pf}), 16'b001);

        pc = 16'h10;
        run_instr("jsrr", 3);
        check("jsrr_pc", pc, 16'h0040);
        check("jsrr_r7", rf[7], 16'h0011);
        run_instr("sti", 4);
        check("sti_mem", mem[16'h50], 16'h7FFF);
        check("sti_pc", pc, 16'h0041);
        run_instr("lea", 3);
        check("lea_r5", rf[5], 16'h0041);
        check("lea_flags", 16'({nf, zf, pf}), 16'b001);

        pc = 16'h43;
        run_instr("trap", 3);
`ifdef PUNC_HALT_EN
        check("trap_state", 16'(state), 16'd4);
        for (int i = 0; i < 10; i++) tick();
        check("halt_state", 16'(state), 16'd4);
        check("halt_halted", 16'(halted), 16'd1);
        check("halt_pc", pc, 16'h0044);
        check("halt_pc_inc", 16'(PC_inc), 16'd0);
`else
        check("trap_state", 16'(state), 16'd0);
        check("trap_halted", 16'(halted), 16'd0);
        check("trap_pc", pc, 16'h0044);
        check("trap_ir_ld", 16'(IR_ld), 16'd1);
`endif

        // Reset asserted in the middle of a ST's EXECUTE cycle
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pc = 16'h44;
        #1;
        tick();
        tick();
        check("st_exe_state", 16'(state), 16'd2);
        check("st_exe_w_en_mem", 16'(w_en_MEM), 16'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_state", 16'(state), 16'd0);
        check("mid_rst_w_en_mem", 16'(w_en_MEM), 16'd0);
        check("mid_rst_pc_clr", 16'(PC_clr), 16'd1);
        tick();
        check("mid_rst_no_store", mem[16'h47], 16'h0);
        #2;
        rst = 1'b0;
        #1;
        check("post_rst_state", 16'(state), 16'd0);
        tick();
        check("post_rst_decode", 16'(state), 16'd1);
        check("post_rst_ir", ir_r, 16'h12BD);
        check("post_rst_pc", pc, 16'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
